// File: rtl/venus_soc_pkg.sv
// Shared AXI4 types, response/burst encodings and the responder range check
// used by the SoC fabric endpoints.
package venus_soc_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef logic [AXI_ADDR_W-1:0]   axi_addr_t;
    typedef logic [AXI_DATA_W-1:0]   axi_data_t;
    typedef logic [AXI_DATA_W/8-1:0] axi_strb_t;
    typedef logic [AXI_ID_W-1:0]     axi_id_t;
    typedef logic [7:0]              axi_len_t;
    typedef logic [2:0]              axi_size_t;
    typedef logic [1:0]              axi_burst_t;
    typedef logic [1:0]              axi_rsp_t;

    typedef struct packed {
        axi_id_t    aw_id;
        axi_addr_t  aw_addr;
        axi_len_t   aw_len;
        axi_size_t  aw_size;
        axi_burst_t aw_burst;
        logic       aw_valid;
        axi_data_t  w_data;
        axi_strb_t  w_strb;
        logic       w_last;
        logic       w_valid;
        logic       b_ready;
        axi_id_t    ar_id;
        axi_addr_t  ar_addr;
        axi_len_t   ar_len;
        axi_size_t  ar_size;
        axi_burst_t ar_burst;
        logic       ar_valid;
        logic       r_ready;
    } axi_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      w_ready;
        logic      b_valid;
        axi_id_t   b_id;
        axi_rsp_t  b_resp;
        logic      ar_ready;
        logic      r_valid;
        axi_id_t   r_id;
        axi_data_t r_data;
        axi_rsp_t  r_resp;
        logic      r_last;
    } axi_resp_t;

    // True when a burst starting at addr falls outside [base, base + depth words)
    // or uses a beat size other than the full bus width.
    function automatic logic axi_burst_err(
        input axi_addr_t   addr,
        input axi_size_t   size,
        input axi_len_t    len,
        input axi_addr_t   base,
        input int unsigned size_log2,
        input int unsigned depth
    );
        logic [AXI_ADDR_W:0] end_idx;
        end_idx = ({1'b0, addr - base} >> size_log2)
                + (AXI_ADDR_W+1)'(len) + (AXI_ADDR_W+1)'(1);
        return (addr < base) || (32'(size) != size_log2)
            || (end_idx > (AXI_ADDR_W+1)'(depth));
    endfunction

endpackage

// File: rtl/axi_slv_mem_array.sv
// Word storage for axi_slv_mem: one byte-strobed synchronous write port and
// one asynchronous read port. Kept separate so an SRAM macro can replace it.
module axi_slv_mem_array
    import venus_soc_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  axi_data_t                wdata_i,
    input  axi_strb_t                wstrb_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output axi_data_t                rdata_o
);

    localparam int unsigned NB = $bits(axi_data_t) / 8;

    axi_data_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_slv_mem.sv
// AXI4 responder over a byte-strobed word memory: independent read and write
// FSMs, one outstanding burst each, SLVERR for out-of-range or bad-size bursts.
module axi_slv_mem
    import venus_soc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter axi_addr_t   BASE_ADDR = '0
) (
    input  logic      clk,
    input  logic      rstn,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o,
    input  logic      rd_stall_i,
    input  logic      wr_stall_i
);

    localparam int unsigned NB = $bits(axi_data_t) / 8;
    localparam int unsigned SZ = $clog2(NB);
    localparam int unsigned IW = $clog2(MEM_DEPTH);

    typedef logic [IW-1:0] idx_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    function automatic idx_t word_idx(input axi_addr_t addr);
        axi_addr_t off;
        off = (addr - BASE_ADDR) >> SZ;
        return idx_t'(off);
    endfunction

    // Burst type is ignored; every burst is handled as INCR.
    logic unused_burst;
    assign unused_burst = ^{axi_req_i.aw_burst, axi_req_i.ar_burst};

    rd_state_e rd_state_q;
    axi_id_t   ar_id_q;
    idx_t      rd_idx_q;
    axi_len_t  ar_len_q;
    axi_len_t  rd_beat_q;
    logic      rd_err_q;

    wr_state_e wr_state_q;
    axi_id_t   aw_id_q;
    idx_t      wr_idx_q;
    axi_len_t  aw_len_q;
    axi_len_t  wr_beat_q;
    logic      wr_err_q;
    logic      wr_proto_q;

    logic      r_active;
    logic      r_hs;
    logic      r_final;
    logic      w_hs;
    logic      w_final;
    logic      mem_we;
    axi_data_t mem_rdata;

    assign r_active = (rd_state_q == R_BURST);
    assign r_hs     = r_active && !rd_stall_i && axi_req_i.r_ready;
    assign r_final  = (rd_beat_q == ar_len_q);
    assign w_hs     = (wr_state_q == W_DATA) && !wr_stall_i && axi_req_i.w_valid;
    assign w_final  = (wr_beat_q == aw_len_q);
    assign mem_we   = w_hs && !wr_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= R_IDLE;
            ar_id_q    <= '0;
            rd_idx_q   <= '0;
            ar_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (axi_req_i.ar_valid) begin
                        ar_id_q    <= axi_req_i.ar_id;
                        rd_idx_q   <= word_idx(axi_req_i.ar_addr);
                        ar_len_q   <= axi_req_i.ar_len;
                        rd_beat_q  <= '0;
                        rd_err_q   <= axi_burst_err(axi_req_i.ar_addr, axi_req_i.ar_size,
                                                    axi_req_i.ar_len, BASE_ADDR, SZ, MEM_DEPTH);
                        rd_state_q <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_hs) begin
                        rd_beat_q <= rd_beat_q + axi_len_t'(1);
                        rd_idx_q  <= rd_idx_q + idx_t'(1);
                        if (r_final) begin
                            rd_state_q <= R_IDLE;
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // The burst closes on the beat count alone; a wlast disagreement only
    // marks the burst for SLVERR, it never shortens or extends it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= W_IDLE;
            aw_id_q    <= '0;
            wr_idx_q   <= '0;
            aw_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_err_q   <= 1'b0;
            wr_proto_q <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (axi_req_i.aw_valid) begin
                        aw_id_q    <= axi_req_i.aw_id;
                        wr_idx_q   <= word_idx(axi_req_i.aw_addr);
                        aw_len_q   <= axi_req_i.aw_len;
                        wr_beat_q  <= '0;
                        wr_err_q   <= axi_burst_err(axi_req_i.aw_addr, axi_req_i.aw_size,
                                                    axi_req_i.aw_len, BASE_ADDR, SZ, MEM_DEPTH);
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (axi_req_i.w_last != w_final) begin
                            wr_proto_q <= 1'b1;
                        end
                        wr_beat_q <= wr_beat_q + axi_len_t'(1);
                        wr_idx_q  <= wr_idx_q + idx_t'(1);
                        if (w_final) begin
                            wr_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_req_i.b_ready) begin
                        wr_err_q   <= 1'b0;
                        wr_proto_q <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = (rd_state_q == R_IDLE);
        axi_resp_o.r_valid  = r_active && !rd_stall_i;
        axi_resp_o.r_id     = ar_id_q;
        axi_resp_o.r_last   = r_active && r_final;
        axi_resp_o.r_resp   = (r_active && rd_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_resp_o.r_data   = (r_active && !rd_err_q) ? mem_rdata : '0;
        axi_resp_o.aw_ready = (wr_state_q == W_IDLE);
        axi_resp_o.w_ready  = (wr_state_q == W_DATA) && !wr_stall_i;
        axi_resp_o.b_valid  = (wr_state_q == W_RESP);
        axi_resp_o.b_id     = aw_id_q;
        axi_resp_o.b_resp   = ((wr_state_q == W_RESP) && (wr_err_q || wr_proto_q))
                            ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end

    axi_slv_mem_array #(
        .DEPTH (MEM_DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_idx_q),
        .wdata_i (axi_req_i.w_data),
        .wstrb_i (axi_req_i.w_strb),
        .raddr_i (rd_idx_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed and randomized bursts against axi_slv_mem, checked against a
// word-array reference model computed from the address/strobe rules.
module tb_axi_slv_mem;
    import venus_soc_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic      clk = 1'b0;
    logic      rstn = 1'b0;
    axi_req_t  req;
    axi_resp_t rsp;
    logic      rd_stall;
    logic      wr_stall;

    always #5 clk = ~clk;

    axi_slv_mem #(
        .MEM_DEPTH (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .axi_req_i  (req),
        .axi_resp_o (rsp),
        .rd_stall_i (rd_stall),
        .wr_stall_i (wr_stall)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [int];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] addr, input int size, input int len);
        longint a = longint'(addr);
        longint b = longint'(BASE);
        if (a < b) return 1'b1;
        if (size != 2) return 1'b1;
        return ((a - b) / 4 + len + 1) > DEPTH;
    endfunction

    function automatic void m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[idx] = w;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        return mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx;
    endfunction

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int wlast_beat, input bit stall);
        bit err;
        int bidx;
        int beat;
        int n;
        err  = m_err(addr, size, len);
        bidx = int'((longint'(addr) - longint'(BASE)) / 4);
        @(negedge clk);
        req.aw_valid = 1'b1;
        req.aw_id    = id;
        req.aw_addr  = addr;
        req.aw_len   = 8'(len);
        req.aw_size  = 3'(size);
        req.aw_burst = AXI_BURST_INCR;
        #1;
        n = 0;
        while (!rsp.aw_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) chk("aw_timeout", 0, 1);
        @(negedge clk);
        req.aw_valid = 1'b0;
        beat = 0;
        n    = 0;
        while (beat <= len && n < 3000) begin
            req.w_valid = 1'b1;
            req.w_data  = wdat[beat];
            req.w_strb  = wstb[beat];
            req.w_last  = (beat == wlast_beat);
            wr_stall    = stall && n > 0 && ($urandom_range(0, 3) == 0);
            #1;
            if (n == 0) chk("wready_first", rsp.w_ready, 1);
            if (rsp.w_ready) begin
                if (!err) m_write(bidx + beat, wdat[beat], wstb[beat]);
                beat++;
            end
            n++;
            @(negedge clk);
        end
        if (beat <= len) chk("w_timeout", 0, 1);
        req.w_valid = 1'b0;
        req.w_last  = 1'b0;
        wr_stall    = 1'b0;
        req.b_ready = 1'b1;
        #1;
        chk("bvalid_next", rsp.b_valid, 1);
        chk("bresp", rsp.b_resp, (err || wlast_beat != len) ? 2 : 0);
        chk("bid", rsp.b_id, id);
        @(negedge clk);
        req.b_ready = 1'b0;
        #1;
        chk("awready_after_b", rsp.aw_ready, 1);
        chk("bvalid_clear", rsp.b_valid, 0);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input bit toggle, input bit stall);
        bit          err;
        int          bidx;
        int          beat;
        int          n;
        bit          held;
        bit          done;
        logic [31:0] pdata;
        err  = m_err(addr, size, len);
        bidx = int'((longint'(addr) - longint'(BASE)) / 4);
        @(negedge clk);
        req.ar_valid = 1'b1;
        req.ar_id    = id;
        req.ar_addr  = addr;
        req.ar_len   = 8'(len);
        req.ar_size  = 3'(size);
        req.ar_burst = AXI_BURST_INCR;
        #1;
        n = 0;
        while (!rsp.ar_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) chk("ar_timeout", 0, 1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        beat  = 0;
        n     = 0;
        held  = 1'b0;
        done  = 1'b0;
        pdata = '0;
        while (!done && n < 3000) begin
            req.r_ready = toggle ? n[0] : 1'b1;
            rd_stall    = stall && n > 0 && ($urandom_range(0, 3) == 0);
            #1;
            if (n == 0) chk("rvalid_first", rsp.r_valid, 1);
            if (rsp.r_valid) begin
                chk("rid", rsp.r_id, id);
                chk("rresp", rsp.r_resp, err ? 2 : 0);
                chk("rdata", rsp.r_data, err ? 32'h0 : m_read(bidx + beat));
                chk("rlast", rsp.r_last, beat == len);
                if (held) chk("rhold", rsp.r_data, pdata);
            end
            held  = rsp.r_valid && !req.r_ready;
            pdata = rsp.r_data;
            if (rsp.r_valid && req.r_ready) begin
                done = (beat == len);
                beat++;
            end
            n++;
            @(negedge clk);
        end
        if (!done) chk("r_timeout", 0, 1);
        req.r_ready = 1'b0;
        rd_stall    = 1'b0;
        #1;
        chk("arready_after_r", rsp.ar_ready, 1);
        chk("rvalid_idle", rsp.r_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int start;
        req      = '0;
        rd_stall = 1'b0;
        wr_stall = 1'b0;
        rstn     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arready", rsp.ar_ready, 1);
        chk("rst_awready", rsp.aw_ready, 1);
        chk("rst_wready", rsp.w_ready, 0);
        chk("rst_bvalid", rsp.b_valid, 0);
        chk("rst_rvalid", rsp.r_valid, 0);
        chk("rst_rlast", rsp.r_last, 0);
        chk("rst_rdata", rsp.r_data, 0);
        chk("rst_rresp", rsp.r_resp, 0);
        chk("rst_rid", rsp.r_id, 0);
        chk("rst_bid", rsp.b_id, 0);
        chk("rst_bresp", rsp.b_resp, 0);
        @(negedge clk);
        rstn = 1'b1;

        // single beat
        wdat[0] = 32'hDEAD_BEEF;
        wstb[0] = 4'hF;
        wr_burst(4'd1, BASE, 0, 2, 0, 1'b0);
        rd_burst(4'd2, BASE, 0, 2, 1'b0, 1'b0);

        // 16-beat INCR, read with rready toggling
        for (int i = 0; i < 16; i++) begin
            wdat[i] = 32'(i) * 32'h1111_1111;
            wstb[i] = 4'hF;
        end
        wr_burst(4'd1, BASE + 32'h40, 15, 2, 15, 1'b0);
        rd_burst(4'd2, BASE + 32'h40, 15, 2, 1'b1, 1'b0);

        // strobes
        wdat[0] = 32'hFFFF_FFFF;
        wstb[0] = 4'hF;
        wr_burst(4'd1, BASE + 32'h100, 0, 2, 0, 1'b0);
        wdat[0] = 32'h0000_0000;
        wstb[0] = 4'b0101;
        wr_burst(4'd1, BASE + 32'h100, 0, 2, 0, 1'b0);
        rd_burst(4'd2, BASE + 32'h100, 0, 2, 1'b0, 1'b0);

        // range errors
        wdat[0] = $urandom();
        wdat[1] = $urandom();
        wstb[0] = 4'hF;
        wstb[1] = 4'hF;
        wr_burst(4'd4, BASE + (DEPTH - 2) * 4, 1, 2, 1, 1'b0);
        rd_burst(4'd4, BASE + (DEPTH - 2) * 4, 3, 2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom();
            wstb[i] = 4'hF;
        end
        wr_burst(4'd4, BASE + (DEPTH - 2) * 4, 3, 2, 3, 1'b0);
        rd_burst(4'd4, BASE + (DEPTH - 2) * 4, 1, 2, 1'b0, 1'b0);
        rd_burst(4'd4, BASE + 32'h40, 0, 1, 1'b0, 1'b0);
        rd_burst(4'd4, BASE - 32'h4, 0, 2, 1'b0, 1'b0);

        // concurrent 256-beat write and read on disjoint ranges with stalls
        for (int i = 0; i < 256; i++) begin
            wdat[i] = $urandom();
            wstb[i] = 4'hF;
        end
        wr_burst(4'd0, BASE + 256 * 4, 255, 2, 255, 1'b0);
        for (int i = 0; i < 256; i++) wdat[i] = $urandom();
        fork
            wr_burst(4'd3, BASE + 600 * 4, 255, 2, 255, 1'b1);
            rd_burst(4'd5, BASE + 256 * 4, 255, 2, 1'b0, 1'b1);
        join
        rd_burst(4'd6, BASE + 600 * 4, 255, 2, 1'b0, 1'b0);

        // early wlast
        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom();
            wstb[i] = 4'hF;
        end
        wr_burst(4'd7, BASE + 32'h200, 3, 2, 1, 1'b0);

        // random partial-strobe bursts over already-written words
        for (int k = 0; k < 6; k++) begin
            len   = $urandom_range(0, 15);
            start = 256 + $urandom_range(0, 240);
            for (int i = 0; i <= len; i++) begin
                wdat[i] = $urandom();
                wstb[i] = 4'($urandom_range(0, 15));
            end
            wr_burst(4'($urandom_range(0, 15)), BASE + 32'(start) * 4, len, 2, len, 1'($urandom_range(0, 1)));
            rd_burst(4'($urandom_range(0, 15)), BASE + 32'(start) * 4, len, 2,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a read burst
        @(negedge clk);
        req.ar_valid = 1'b1;
        req.ar_id    = 4'd9;
        req.ar_addr  = BASE;
        req.ar_len   = 8'd7;
        req.ar_size  = 3'd2;
        #1;
        n = 0;
        while (!rsp.ar_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) chk("abort_ar_timeout", 0, 1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_midburst_rvalid", rsp.r_valid, 1);
        rstn = 1'b0;
        #1;
        chk("abort_rvalid", rsp.r_valid, 0);
        chk("abort_arready", rsp.ar_ready, 1);
        req.r_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("abort_no_r", rsp.r_valid, 0);
        chk("abort_arready_after", rsp.ar_ready, 1);
        rd_burst(4'd10, BASE, 0, 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
